// File: rtl/oled_source_switcher.sv
// Frame-aligned source switcher for the OLED pixel path: synchronizes the
// select switches and blanks for a set number of frames before showing a new source.
module oled_source_switcher #(
    parameter int unsigned BLANK_FRAMES = 2,
    parameter logic [15:0] BLANK_COLOR  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  sel_sw,
    input  logic        frame_begin,
    input  logic [15:0] src_a,
    input  logic [15:0] src_b,
    input  logic [15:0] src_d,
    output logic [15:0] pixel_data,
    output logic [1:0]  active_src,
    output logic        switching
);

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_A    = 2'd1;
    localparam logic [1:0] SRC_B    = 2'd2;
    localparam logic [1:0] SRC_D    = 2'd3;
    localparam logic [3:0] BLANK_LAST = 4'(BLANK_FRAMES);

    typedef enum logic [1:0] {SHOW, WAIT_FRAME, BLANK} state_t;

    state_t      state_q, state_d;
    logic [2:0]  sync1_q, sync2_q;
    logic [1:0]  req;
    logic [1:0]  active_q, active_d;
    logic [1:0]  pending_q, pending_d;
    logic [3:0]  blank_cnt_q, blank_cnt_d;
    logic [3:0]  blank_cnt_inc;
    logic [15:0] pixel_q, pixel_d;
    logic        switching_q, switching_d;

    always_comb begin
        req = SRC_NONE;
        if (sync2_q[0])      req = SRC_A;
        else if (sync2_q[1]) req = SRC_B;
        else if (sync2_q[2]) req = SRC_D;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SHOW;
            sync1_q     <= '0;
            sync2_q     <= '0;
            active_q    <= SRC_NONE;
            pending_q   <= SRC_NONE;
            blank_cnt_q <= '0;
            pixel_q     <= BLANK_COLOR;
            switching_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sel_sw;
            sync2_q     <= sync1_q;
            active_q    <= active_d;
            pending_q   <= pending_d;
            blank_cnt_q <= blank_cnt_d;
            pixel_q     <= pixel_d;
            switching_q <= switching_d;
        end
    end

    assign blank_cnt_inc = blank_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        pending_d   = pending_q;
        blank_cnt_d = blank_cnt_q;
        case (state_q)
            SHOW: begin
                // A frame_begin coinciding with the change is deliberately ignored here
                if (req != active_q) begin
                    pending_d = req;
                    state_d   = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (req == active_q) begin
                    state_d = SHOW;
                end else begin
                    pending_d = req;
                    if (frame_begin) begin
                        blank_cnt_d = '0;
                        state_d     = BLANK;
                    end
                end
            end
            BLANK: begin
                pending_d = req;
                if (frame_begin) begin
                    blank_cnt_d = blank_cnt_inc;
                    if (blank_cnt_inc == BLANK_LAST) begin
                        active_d = pending_q;
                        state_d  = SHOW;
                    end
                end
            end
            default: state_d = SHOW;
        endcase
    end

    // Outputs are registered from the next state so they line up with active_src
    always_comb begin
        pixel_d     = BLANK_COLOR;
        switching_d = (state_d != SHOW);
        if (state_d != BLANK) begin
            case (active_d)
                SRC_A:   pixel_d = src_a;
                SRC_B:   pixel_d = src_b;
                SRC_D:   pixel_d = src_d;
                default: pixel_d = BLANK_COLOR;
            endcase
        end
    end

    assign pixel_data = pixel_q;
    assign active_src = active_q;
    assign switching  = switching_q;

endmodule

// File: tb/tb_oled_source_switcher.sv
// Bench for oled_source_switcher: per-cycle vector table with a queue of
// expected outputs, plus hand-written reset sequences.
module tb_oled_source_switcher;

    localparam logic [15:0] PA = 16'hA1A1;
    localparam logic [15:0] PB = 16'hB2B2;
    localparam logic [15:0] PD = 16'hD3D3;

    typedef struct {
        logic [2:0]  sel;
        logic        fb;
        logic [15:0] a;
        logic [15:0] px;
        logic [1:0]  act;
        logic        sw;
    } vec_t;

    typedef struct {
        logic [15:0] px;
        logic [1:0]  act;
        logic        sw;
        int          id;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [2:0]  sel_sw;
    logic        frame_begin;
    logic [15:0] src_a, src_b, src_d;
    logic [15:0] pixel_data;
    logic [1:0]  active_src;
    logic        switching;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    oled_source_switcher #(.BLANK_FRAMES(2), .BLANK_COLOR(16'h0000)) dut (
        .clk(clk), .reset_n(reset_n), .sel_sw(sel_sw), .frame_begin(frame_begin),
        .src_a(src_a), .src_b(src_b), .src_d(src_d),
        .pixel_data(pixel_data), .active_src(active_src), .switching(switching)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_id, got, exp);
        end
    endtask

    task automatic add(input logic [2:0] sel, input logic fb, input logic [15:0] a,
                       input logic [15:0] px, input logic [1:0] act, input logic sw);
        vec_t v;
        v.sel = sel; v.fb = fb; v.a = a; v.px = px; v.act = act; v.sw = sw;
        vecs.push_back(v);
    endtask

    // Drive one cycle at the falling edge, then compare after the next rising edge
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got_e;
        sel_sw      = v.sel;
        frame_begin = v.fb;
        src_a       = v.a;
        e.px = v.px; e.act = v.act; e.sw = v.sw; e.id = step_id;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got_e = sb.pop_front();
        chk("pixel_data", pixel_data, got_e.px);
        chk("active_src", 16'(active_src), 16'(got_e.act));
        chk("switching", 16'(switching), 16'(got_e.sw));
        step_id++;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_pixel"}, pixel_data, 16'h0000);
        chk({tag, "_active"}, 16'(active_src), 16'd0);
        chk({tag, "_switching"}, 16'(switching), 16'd0);
    endtask

    initial begin
        // Power-on sequence, SHOW/A, priority, cancel, latency, retarget, simultaneous
        add(3'b001,0,PA,16'h0000,0,0); add(3'b001,0,PA,16'h0000,0,0);
        add(3'b001,0,PA,16'h0000,0,1); add(3'b001,1,PA,16'h0000,0,1);
        add(3'b001,0,PA,16'h0000,0,1); add(3'b001,1,PA,16'h0000,0,1);
        add(3'b001,0,PA,16'h0000,0,1); add(3'b001,1,PA,PA,1,0);
        add(3'b001,0,PA,PA,1,0);
        add(3'b110,0,PA,PA,1,0); add(3'b110,0,PA,PA,1,0);
        add(3'b110,0,PA,PA,1,1); add(3'b110,1,PA,16'h0000,1,1);
        add(3'b110,1,PA,16'h0000,1,1); add(3'b110,1,PA,PB,2,0);
        add(3'b111,0,PA,PB,2,0); add(3'b111,0,PA,PB,2,0);
        add(3'b111,0,PA,PB,2,1); add(3'b111,1,PA,16'h0000,2,1);
        add(3'b111,1,PA,16'h0000,2,1); add(3'b111,1,PA,PA,1,0);
        add(3'b010,0,PA,PA,1,0); add(3'b001,0,PA,PA,1,0);
        add(3'b001,0,PA,PA,1,1); add(3'b001,0,PA,PA,1,0);
        add(3'b001,0,16'h5A5A,16'h5A5A,1,0);
        add(3'b010,0,PA,PA,1,0); add(3'b010,0,PA,PA,1,0);
        add(3'b010,0,PA,PA,1,1); add(3'b010,1,PA,16'h0000,1,1);
        add(3'b100,0,PA,16'h0000,1,1); add(3'b100,0,PA,16'h0000,1,1);
        add(3'b100,0,PA,16'h0000,1,1); add(3'b100,1,PA,16'h0000,1,1);
        add(3'b100,1,PA,PD,3,0);
        add(3'b001,0,PA,PD,3,0); add(3'b001,0,PA,PD,3,0);
        add(3'b001,1,PA,PD,3,1); add(3'b001,0,PA,PD,3,1);
        add(3'b001,1,PA,16'h0000,3,1); add(3'b001,1,PA,16'h0000,3,1);
        add(3'b001,1,PA,PA,1,0);
        // Enter BLANK towards B, to be interrupted by reset
        add(3'b010,0,PA,PA,1,0); add(3'b010,0,PA,PA,1,0);
        add(3'b010,0,PA,PA,1,1); add(3'b010,1,PA,16'h0000,1,1);
        add(3'b010,0,PA,16'h0000,1,1);

        reset_n = 1'b1; sel_sw = 3'b000; frame_begin = 1'b0;
        src_a = PA; src_b = PB; src_d = PD;
        #1 reset_n = 1'b0;
        #1 reset_checks("por");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) step(vecs[i]);

        // Reset in the middle of BLANK must clear outputs without a clock edge
        #2 reset_n = 1'b0;
        #1 reset_checks("async_rst");
        sel_sw = 3'b010;
        repeat (2) @(negedge clk);
        reset_checks("held_rst");
        reset_n = 1'b1;

        // Pending change was discarded; a held select is handled as a fresh change
        vecs.delete();
        add(3'b010,0,PA,16'h0000,0,0); add(3'b010,0,PA,16'h0000,0,0);
        add(3'b010,0,PA,16'h0000,0,1); add(3'b010,1,PA,16'h0000,0,1);
        add(3'b010,1,PA,16'h0000,0,1); add(3'b010,1,PA,PB,2,0);
        add(3'b010,0,PA,PB,2,0);
        foreach (vecs[i]) step(vecs[i]);

        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oled_source_switcher.md
OLED_SOURCE_SWITCHER -- requirements
Module: oled_source_switcher

Interface
REQ-001 The block SHALL have parameter BLANK_FRAMES, default 2, giving the number of frame_begin pulses spent blanked during a source change (legal range 1..15).
REQ-002 The block SHALL have parameter BLANK_COLOR, default 16'h0000, giving the RGB565 value driven while blanked or when no source is selected.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, the same clock that samples frame_begin.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port sel_sw, input, 3 bits: asynchronous source-select switches; bit0 selects A, bit1 selects B, bit2 selects D.
REQ-006 The block SHALL have port frame_begin, input, 1 bit: single-cycle pulse from the OLED driver marking the start of a frame.
REQ-007 The block SHALL have ports src_a, src_b and src_d, each input, 16 bits: RGB565 pixel data from task generators A, B and D for the current pixel_index.
REQ-008 The block SHALL have port pixel_data, output, 16 bits: registered RGB565 pixel to the OLED driver.
REQ-009 The block SHALL have port active_src, output, 2 bits: currently displayed source, encoded 0=NONE, 1=A, 2=B, 3=D.
REQ-010 The block SHALL have port switching, output, 1 bit: high while a source change is pending or blanking.

Function
REQ-011 sel_sw SHALL pass through a 2-flop synchronizer before use; the requested source (req) SHALL be decoded from the synchronized value with priority bit0 > bit1 > bit2, and all-zero SHALL give NONE.
REQ-012 The state machine SHALL have three states: SHOW, WAIT_FRAME and BLANK.
REQ-013 SHOW: pixel_data SHALL follow the active source; if req != active_src, the block SHALL latch pending <= req and move to WAIT_FRAME.
REQ-014 WAIT_FRAME: the block SHALL keep showing the active source.
- If req == active_src, it SHALL return to SHOW (cancel).
- Otherwise, if req changes, pending SHALL update to req.
- On frame_begin, it SHALL move to BLANK with blank_cnt <= 0.
REQ-015 BLANK: pixel_data SHALL be BLANK_COLOR.
- Each frame_begin SHALL increment blank_cnt (4 bits).
- pending SHALL track req on every cycle.
- On the frame_begin that makes blank_cnt reach BLANK_FRAMES, the block SHALL set active_src <= pending and move to SHOW, so the new source starts exactly at a frame boundary.
REQ-016 A req change during BLANK SHALL NOT restart blank_cnt.
REQ-017 If pending equals the old active_src when BLANK completes, the block SHALL still return to SHOW with the same source; the blanking is not aborted mid-way.
REQ-018 active_src == NONE SHALL drive BLANK_COLOR in SHOW.
REQ-019 pixel_data SHALL be registered: the value at cycle n+1 SHALL reflect the src_* inputs and the state at cycle n (latency 1 cycle).
REQ-020 switching SHALL be a registered output equal to (state != SHOW).
REQ-021 frame_begin and a req change in the same cycle in SHOW SHALL move the block only to WAIT_FRAME; that frame_begin SHALL NOT count toward blanking.

Reset
REQ-022 While reset_n is low, the block SHALL asynchronously force: state=SHOW, active_src=0, pending=0, blank_cnt=0, synchronizer flops=0, pixel_data=BLANK_COLOR, switching=0.
REQ-023 Reset asserted mid-BLANK or mid-WAIT_FRAME SHALL discard the pending change.
REQ-024 After reset_n deasserts, a nonzero sel_sw SHALL be treated as a normal change: the block SHALL go through WAIT_FRAME and BLANK before the source is shown.

Verification
REQ-025 Reset then sel_sw=3'b001, BLANK_FRAMES=2 -> the bench SHALL see 2 sync cycles, then switching=1; pixel_data SHALL stay 0000 through two frame_begin pulses after the first one; active_src=1 and pixel_data=src_a one cycle after the 3rd frame_begin.
REQ-026 Priority: sel_sw=3'b110 -> the bench SHALL see active_src=2; then sel_sw=3'b111 -> active_src=1 after blanking.
REQ-027 Cancel: in SHOW with active=A, set sel_sw=3'b010 and restore 3'b001 before any frame_begin -> the bench SHALL see switching pulse high then low, no blank pixels, and active_src unchanged at 1.
REQ-028 Retarget during BLANK: change A->B, then during blank set sel_sw=3'b100 -> the bench SHALL see the blank length still 2 frames and active_src=3.
REQ-029 Simultaneous events: a req change coinciding with frame_begin -> the bench SHALL see WAIT_FRAME entered, with blanking beginning only at the next frame_begin.
REQ-030 Reset mid-BLANK: assert reset_n=0 -> the bench SHALL see pixel_data=0000, switching=0 and active_src=0 immediately, without waiting for a clock edge.
